mac_lookup_sched: RTL and testbench

Sequencer that shares the single MAC-learning engine between the per-lane MAC-request FIFOs. Round-robin selects a non-empty FIFO, pops one entry, presents it to the learning engine with a start pulse and lane tag, then waits for `done`. The looked-up destination port is routed back to the originating lane. A watchdog forces a flood response if the engine never answers. It replaces the loose arbiter/mux/demux glue between the FCS checkers and the MAC learning block.

---
 rtl/switch_pkg.sv | 26 ++
 rtl/rr_pick.sv | 34 +++
 rtl/mac_lookup_sched.sv | 116 +++++++++++
 tb/tb_mac_lookup_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared switch definitions: flood port code, MAC-request entry layout and
// the state encoding of the MAC-lookup sequencer.
package switch_pkg;

    localparam logic [2:0] DST_FLOOD = 3'b111;

    localparam int MAC_W        = 48;
    localparam int PORT_W       = 3;
    localparam int SRC_MAC_LSB  = 51;
    localparam int DST_MAC_LSB  = 3;
    localparam int SRC_PORT_LSB = 0;
    localparam int ENTRY_BITS   = 2 * MAC_W + PORT_W;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        ISSUE,
        WAIT
    } lk_state_t;

    function automatic logic [MAC_W-1:0] entry_dst_mac(input logic [ENTRY_BITS-1:0] entry);
        return entry[DST_MAC_LSB +: MAC_W];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first requester searching upward from last+1.
// Zero latency; no state, the caller owns the last-grant pointer.
module rr_pick
    import switch_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 1; i <= N; i++) begin
            // Modulo keeps the wrap correct for non-power-of-two lane counts.
            cand = IDX_W'((int'(last) + i) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_lookup_sched.sv
// Shares one MAC-learning engine across per-lane request FIFOs, one lookup in flight.
// Pop 1 cycle after grant, lk_en 3 cycles after grant, response 1 cycle after lk_done; stalls while lk_busy.
module mac_lookup_sched
    import switch_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int ENTRY_W = 99,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_PORTS-1:0]           req_empty,
    input  logic [N_PORTS*ENTRY_W-1:0]   req_data,
    output logic [N_PORTS-1:0]           req_rd,
    output logic                         lk_en,
    output logic [ENTRY_W-1:0]           lk_data,
    output logic [$clog2(N_PORTS)-1:0]   lk_tag,
    input  logic                         lk_busy,
    input  logic                         lk_done,
    input  logic [2:0]                   lk_dst_port,
    output logic [N_PORTS-1:0]           rsp_valid,
    output logic [2:0]                   rsp_dst_port,
    output logic                         timeout_err
);

    localparam int TAG_W = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [N_PORTS-1:0] LANE0    = N_PORTS'(1);

    lk_state_t          state;
    logic [TAG_W-1:0]   grant;
    logic [TAG_W-1:0]   last_grant;
    logic [CNT_W-1:0]   wd_cnt;

    logic [N_PORTS-1:0] pick_req;
    logic [N_PORTS-1:0] pick_gnt;
    logic [TAG_W-1:0]   pick_idx;
    logic               pick_any;

    // A busy engine hides every request so nothing is popped that cannot be issued.
    assign pick_req = lk_busy ? '0 : ~req_empty;

    rr_pick #(
        .N     (N_PORTS),
        .IDX_W (TAG_W)
    ) u_pick (
        .req  (pick_req),
        .last (last_grant),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= '0;
            last_grant   <= TAG_W'(N_PORTS - 1);
            wd_cnt       <= '0;
            req_rd       <= '0;
            lk_en        <= 1'b0;
            lk_data      <= '0;
            lk_tag       <= '0;
            rsp_valid    <= '0;
            rsp_dst_port <= '0;
            timeout_err  <= 1'b0;
        end else begin
            req_rd      <= '0;
            lk_en       <= 1'b0;
            rsp_valid   <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant  <= pick_idx;
                        req_rd <= pick_gnt;
                        state  <= RD;
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    // FIFO read data is valid the cycle after the pop strobe.
                    lk_data <= req_data[int'(grant)*ENTRY_W +: ENTRY_W];
                    lk_tag  <= grant;
                    lk_en   <= 1'b1;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (lk_done) begin
                        rsp_dst_port <= lk_dst_port;
                        rsp_valid    <= LANE0 << lk_tag;
                        last_grant   <= grant;
                        state        <= IDLE;
                    end else if (wd_cnt == CNT_LAST) begin
                        rsp_dst_port <= DST_FLOOD;
                        rsp_valid    <= LANE0 << lk_tag;
                        timeout_err  <= 1'b1;
                        last_grant   <= grant;
                        state        <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_lookup_sched.sv
// Bench for mac_lookup_sched: FIFO and engine models driven at negedge,
// per-scenario tasks compare logged events against spec-level timing rules.
module tb_mac_lookup_sched;

    localparam int NP  = 4;
    localparam int EW  = 99;
    localparam int TMO = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NP-1:0]    req_empty = '1;
    logic [NP*EW-1:0] req_data = '0;
    logic [NP-1:0]    req_rd;
    logic             lk_en;
    logic [EW-1:0]    lk_data;
    logic [1:0]       lk_tag;
    logic             lk_busy = 1'b0;
    logic             lk_done = 1'b0;
    logic [2:0]       lk_dst_port = '0;
    logic [NP-1:0]    rsp_valid;
    logic [2:0]       rsp_dst_port;
    logic             timeout_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { int cyc; logic [NP-1:0] vec; } pop_ev_t;
    typedef struct { int cyc; logic [1:0] tag; logic [EW-1:0] dat; logic [2:0] port; } iss_ev_t;
    typedef struct { int cyc; logic [NP-1:0] vec; logic [2:0] port; logic terr; } rsp_ev_t;

    pop_ev_t       pops[$];
    iss_ev_t       iss[$];
    rsp_ev_t       rsps[$];
    logic [EW-1:0] fifo [NP][$];
    logic [EW-1:0] mq [NP][$];
    int            lat_q[$];
    logic [2:0]    port_q[$];
    int            done_cyc = -1;
    int            eng_lat;
    logic [2:0]    done_port;

    mac_lookup_sched #(
        .N_PORTS (NP),
        .ENTRY_W (EW),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_empty    (req_empty),
        .req_data     (req_data),
        .req_rd       (req_rd),
        .lk_en        (lk_en),
        .lk_data      (lk_data),
        .lk_tag       (lk_tag),
        .lk_busy      (lk_busy),
        .lk_done      (lk_done),
        .lk_dst_port  (lk_dst_port),
        .rsp_valid    (rsp_valid),
        .rsp_dst_port (rsp_dst_port),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO + engine model and event monitor; lat -1 means the engine never answers.
    always @(negedge clk) begin
        if (req_rd != '0) begin
            pops.push_back('{cyc: cyc, vec: req_rd});
            for (int i = 0; i < NP; i++)
                if (req_rd[i] && fifo[i].size() > 0) req_data[i*EW +: EW] = fifo[i].pop_front();
        end
        for (int i = 0; i < NP; i++) req_empty[i] = (fifo[i].size() == 0);
        if (lk_en) begin
            eng_lat   = (lat_q.size() > 0) ? lat_q.pop_front() : 3;
            done_port = (port_q.size() > 0) ? port_q.pop_front() : 3'($urandom);
            done_cyc  = (eng_lat > 0) ? cyc + eng_lat : -1;
            iss.push_back('{cyc: cyc, tag: lk_tag, dat: lk_data, port: done_port});
        end
        if (rsp_valid != '0 || timeout_err)
            rsps.push_back('{cyc: cyc, vec: rsp_valid, port: rsp_dst_port, terr: timeout_err});
        lk_done     = (cyc == done_cyc);
        lk_dst_port = lk_done ? done_port : 3'($urandom);
    end

    function automatic logic [EW-1:0] rand_entry();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[EW-1:0];
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        pops.delete(); iss.delete(); rsps.delete(); lat_q.delete(); port_q.delete();
        for (int i = 0; i < NP; i++) begin fifo[i].delete(); mq[i].delete(); end
        done_cyc = -1;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        for (int k = 0; k < budget && rsps.size() < n; k++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({req_rd, lk_en, rsp_valid, timeout_err} !== '0) begin
            $display("FAIL reset_strobes: got %b want 0", {req_rd, lk_en, rsp_valid, timeout_err}); failures++; end
        checks++; if (lk_data !== '0) begin
            $display("FAIL reset_lk_data: got %h want 0", lk_data); failures++; end
        checks++; if (lk_tag !== 2'd0) begin
            $display("FAIL reset_lk_tag: got %0d want 0", lk_tag); failures++; end
        checks++; if (rsp_dst_port !== 3'd0) begin
            $display("FAIL reset_rsp_port: got %0d want 0", rsp_dst_port); failures++; end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [EW-1:0] d;
        int t0;
        apply_reset();
        @(posedge clk); #1;
        t0 = cyc; d = rand_entry();
        fifo[2].push_back(d); lat_q.push_back(4); port_q.push_back(3'd1);
        wait_rsp(1, 40);
        checks++; if (rsps.size() != 1 || iss.size() != 1 || pops.size() != 1) begin
            $display("FAIL single_events: got rsp=%0d iss=%0d pop=%0d want 1/1/1", rsps.size(), iss.size(), pops.size());
            failures++; return; end
        checks++; if (pops[0].cyc != t0 + 1 || pops[0].vec !== 4'b0100) begin
            $display("FAIL single_pop: got cyc %0d vec %b want cyc %0d vec 0100", pops[0].cyc, pops[0].vec, t0 + 1); failures++; end
        checks++; if (iss[0].cyc != t0 + 3 || iss[0].tag !== 2'd2) begin
            $display("FAIL single_issue: got cyc %0d tag %0d want cyc %0d tag 2", iss[0].cyc, iss[0].tag, t0 + 3); failures++; end
        checks++; if (iss[0].dat !== d) begin
            $display("FAIL single_data: got %h want %h", iss[0].dat, d); failures++; end
        checks++; if (rsps[0].cyc != t0 + 8 || rsps[0].vec !== 4'b0100 || rsps[0].port !== 3'd1 || rsps[0].terr !== 1'b0) begin
            $display("FAIL single_rsp: got cyc %0d vec %b port %0d terr %b want cyc %0d vec 0100 port 1 terr 0",
                     rsps[0].cyc, rsps[0].vec, rsps[0].port, rsps[0].terr, t0 + 8); failures++; end
        repeat (5) begin @(negedge clk); #1; end
        checks++; if (lk_data !== d || lk_tag !== 2'd2 || rsps.size() != 1) begin
            $display("FAIL single_hold: got tag %0d rsps %0d data_ok %b want tag 2 rsps 1 data_ok 1", lk_tag, rsps.size(), lk_data === d);
            failures++; end
    endtask

    task automatic test_round_robin();
        int total, last, lane, n, exp_cyc;
        int lats[$];
        logic [EW-1:0] d;
        logic [NP-1:0] exp_vec;
        logic [2:0] exp_port;
        logic exp_terr;
        apply_reset();
        total = 0; last = NP - 1;
        @(posedge clk); #1;
        for (int i = 0; i < NP; i++) begin
            n = $urandom_range(3, 2);
            for (int k = 0; k < n; k++) begin
                d = rand_entry(); fifo[i].push_back(d); mq[i].push_back(d); total++;
            end
        end
        for (int k = 0; k < total; k++) begin
            lats.push_back($urandom_range(TMO + 2, 1)); lat_q.push_back(lats[k]);
        end
        wait_rsp(total, 20 * total);
        checks++; if (rsps.size() != total || iss.size() != total || pops.size() != total) begin
            $display("FAIL rr_events: got rsp=%0d iss=%0d pop=%0d want %0d", rsps.size(), iss.size(), pops.size(), total);
            failures++; return; end
        for (int k = 0; k < total; k++) begin
            lane = 0;
            for (int s = NP; s >= 1; s--) if (mq[(last + s) % NP].size() > 0) lane = (last + s) % NP;
            d = mq[lane].pop_front();
            exp_vec = '0; exp_vec[lane] = 1'b1;
            if (lats[k] <= TMO) begin exp_cyc = iss[k].cyc + lats[k] + 1; exp_port = iss[k].port; exp_terr = 1'b0; end
            else begin exp_cyc = iss[k].cyc + TMO + 1; exp_port = 3'b111; exp_terr = 1'b1; end
            checks++; if (pops[k].vec !== exp_vec || iss[k].tag !== 2'(lane) || iss[k].cyc != pops[k].cyc + 2) begin
                $display("FAIL rr_grant[%0d]: got pop %b tag %0d dcyc %0d want pop %b tag %0d dcyc 2",
                         k, pops[k].vec, iss[k].tag, iss[k].cyc - pops[k].cyc, exp_vec, lane); failures++; end
            checks++; if (iss[k].dat !== d) begin
                $display("FAIL rr_data[%0d]: got %h want %h", k, iss[k].dat, d); failures++; end
            checks++; if (rsps[k].cyc != exp_cyc || rsps[k].vec !== exp_vec || rsps[k].port !== exp_port || rsps[k].terr !== exp_terr) begin
                $display("FAIL rr_rsp[%0d]: got cyc %0d vec %b port %0d terr %b want cyc %0d vec %b port %0d terr %b (lat %0d)",
                         k, rsps[k].cyc, rsps[k].vec, rsps[k].port, rsps[k].terr, exp_cyc, exp_vec, exp_port, exp_terr, lats[k]);
                failures++; end
            if (k > 0) begin
                checks++; if (pops[k].cyc != rsps[k-1].cyc + 1) begin
                    $display("FAIL rr_b2b[%0d]: got pop cyc %0d want %0d", k, pops[k].cyc, rsps[k-1].cyc + 1); failures++; end
            end
            last = lane;
        end
    endtask

    task automatic test_busy();
        int tb;
        apply_reset();
        @(posedge clk); #1;
        lk_busy = 1'b1; fifo[1].push_back(rand_entry());
        repeat (10) @(posedge clk);
        #1;
        checks++; if (pops.size() != 0) begin
            $display("FAIL busy_hold: got %0d pops want 0", pops.size()); failures++; end
        lk_busy = 1'b0; tb = cyc;
        wait_rsp(1, 40);
        checks++; if (pops.size() != 1 || pops[0].cyc != tb + 1 || pops[0].vec !== 4'b0010) begin
            $display("FAIL busy_release: got pops %0d cyc %0d want 1 pop at cyc %0d lane 1",
                     pops.size(), (pops.size() > 0) ? pops[0].cyc : -1, tb + 1); failures++; end
    endtask

    task automatic test_timeout();
        apply_reset();
        @(posedge clk); #1;
        fifo[1].push_back(rand_entry()); fifo[3].push_back(rand_entry());
        lat_q.push_back(-1); lat_q.push_back(2);
        wait_rsp(2, 80);
        checks++; if (rsps.size() != 2 || iss.size() != 2 || pops.size() != 2) begin
            $display("FAIL tmo_events: got rsp=%0d iss=%0d pop=%0d want 2/2/2", rsps.size(), iss.size(), pops.size());
            failures++; return; end
        checks++; if (iss[0].tag !== 2'd1 || rsps[0].cyc != iss[0].cyc + TMO + 1) begin
            $display("FAIL tmo_when: got tag %0d delay %0d want tag 1 delay %0d", iss[0].tag, rsps[0].cyc - iss[0].cyc, TMO + 1);
            failures++; end
        checks++; if (rsps[0].vec !== 4'b0010 || rsps[0].port !== 3'b111 || rsps[0].terr !== 1'b1) begin
            $display("FAIL tmo_rsp: got vec %b port %0d terr %b want 0010 7 1", rsps[0].vec, rsps[0].port, rsps[0].terr);
            failures++; end
        checks++; if (pops[1].vec !== 4'b1000 || pops[1].cyc != rsps[0].cyc + 1) begin
            $display("FAIL tmo_next_pop: got vec %b cyc %0d want 1000 cyc %0d", pops[1].vec, pops[1].cyc, rsps[0].cyc + 1);
            failures++; end
        checks++; if (rsps[1].cyc != iss[1].cyc + 3 || rsps[1].port !== iss[1].port || rsps[1].terr !== 1'b0 || rsps[1].vec !== 4'b1000) begin
            $display("FAIL tmo_next_rsp: got cyc %0d port %0d terr %b vec %b want cyc %0d port %0d terr 0 vec 1000",
                     rsps[1].cyc, rsps[1].port, rsps[1].terr, rsps[1].vec, iss[1].cyc + 3, iss[1].port); failures++; end
    endtask

    task automatic test_done_race();
        apply_reset();
        @(posedge clk); #1;
        fifo[0].push_back(rand_entry()); fifo[0].push_back(rand_entry());
        lat_q.push_back(TMO); lat_q.push_back(TMO + 1);
        port_q.push_back(3'd2); port_q.push_back(3'd6);
        wait_rsp(2, 80);
        repeat (6) begin @(negedge clk); #1; end
        checks++; if (rsps.size() != 2 || iss.size() != 2) begin
            $display("FAIL race_events: got rsp=%0d iss=%0d want 2/2", rsps.size(), iss.size()); failures++; return; end
        checks++; if (rsps[0].cyc != iss[0].cyc + TMO + 1 || rsps[0].port !== 3'd2 || rsps[0].terr !== 1'b0) begin
            $display("FAIL race_done_wins: got delay %0d port %0d terr %b want delay %0d port 2 terr 0",
                     rsps[0].cyc - iss[0].cyc, rsps[0].port, rsps[0].terr, TMO + 1); failures++; end
        checks++; if (rsps[1].cyc != iss[1].cyc + TMO + 1 || rsps[1].port !== 3'b111 || rsps[1].terr !== 1'b1) begin
            $display("FAIL race_late_done: got delay %0d port %0d terr %b want delay %0d port 7 terr 1",
                     rsps[1].cyc - iss[1].cyc, rsps[1].port, rsps[1].terr, TMO + 1); failures++; end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(posedge clk); #1;
        fifo[2].push_back(rand_entry()); lat_q.push_back(-1);
        for (int k = 0; k < 30 && iss.size() == 0; k++) begin @(negedge clk); #1; end
        checks++; if (iss.size() != 1) begin
            $display("FAIL mid_issue: got %0d issues want 1", iss.size()); failures++; return; end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++; if ({req_rd, lk_en, rsp_valid, timeout_err} !== '0 || lk_data !== '0 || lk_tag !== 2'd0 || rsp_dst_port !== 3'd0) begin
            $display("FAIL mid_reset_outputs: got strobes %b tag %0d port %0d data_zero %b want all 0",
                     {req_rd, lk_en, rsp_valid, timeout_err}, lk_tag, rsp_dst_port, lk_data === '0); failures++; end
        pops.delete(); iss.delete(); rsps.delete();
        repeat (15) begin @(negedge clk); #1; end
        checks++; if (rsps.size() != 0) begin
            $display("FAIL mid_abandon: got %0d responses want 0", rsps.size()); failures++; end
        @(posedge clk); #1;
        fifo[0].push_back(rand_entry()); fifo[3].push_back(rand_entry());
        lat_q.push_back(2); lat_q.push_back(2);
        wait_rsp(2, 40);
        checks++; if (pops.size() != 2 || pops[0].vec !== 4'b0001 || pops[1].vec !== 4'b1000) begin
            $display("FAIL mid_priority: got %0d pops first %b want 2 pops 0001 then 1000",
                     pops.size(), (pops.size() > 0) ? pops[0].vec : 4'b0); failures++; end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_round_robin();
        test_busy();
        test_timeout();
        test_done_race();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
